// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: one log2 stage per clock, applying a 2^k shift
// when bit k of the captured shift amount is set. Valid/ready on both sides.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    state_t             state;
    state_t             state_next;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] shamt_q;
    op_t                op_q;
    logic               sign_q;
    logic [WIDTH-1:0]   stage_out;
    logic               stage_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)         state_next = SHIFT;
            SHIFT:   if (k == LAST_STAGE)  state_next = DONE;
            DONE:    if (out_ready)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Stage k applies a fixed 2^k shift; the loop unrolls into one constant
    // shifter per stage and k selects which one feeds the working register.
    always_comb begin
        stage_out = work;
        stage_en  = 1'b0;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (k == SHAMT_W'(s)) begin
                stage_en = shamt_q[s];
                case (op_q)
                    OP_SLL:  stage_out = work << (1 << s);
                    OP_SRL:  stage_out = work >> (1 << s);
                    OP_SRA:  stage_out = (work >> (1 << s))
                                       | (sign_q ? ~({WIDTH{1'b1}} >> (1 << s)) : '0);
                    default: stage_out = (work << (1 << s)) | (work >> (WIDTH - (1 << s)));
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k       <= '0;
            work    <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            sign_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work    <= in_data;
                        shamt_q <= in_shamt;
                        op_q    <= op_t'(in_op);
                        sign_q  <= in_data[WIDTH-1];
                        k       <= '0;
                    end
                end
                SHIFT: begin
                    if (stage_en) begin
                        work <= stage_out;
                    end
                    k <= k + SHAMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = work;

endmodule

// File: tb/tb_seq_shifter.sv
// Randomized bench for seq_shifter: a cycle-numbered reference model predicts
// handshakes and results; a negedge compare process checks the DUT every cycle.
module tb_seq_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [SW-1:0] in_shamt = '0;
    logic [1:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit           m_busy = 1'b0;
    logic [W-1:0] m_result = '0;
    int           m_valid_cyc = 0;

    seq_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [1:0] op);
        logic signed [W-1:0] sd;
        sd = d;
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return sd >>> s;
            default: return (s == 0) ? d : ((d << s) | (d >> (W - s)));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Reference model: a request is taken on the first edge seen idle with
    // in_valid high, the result appears SW edges later and leaves on the
    // first later edge with out_ready high.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset_n) begin
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy      = 1'b1;
                    m_result    = ref_shift(in_data, int'(in_shamt), in_op);
                    m_valid_cyc = cyc + SW;
                end
            end else if (cyc > m_valid_cyc && out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge reset_n) m_busy = 1'b0;

    always @(negedge clock) begin
        logic exp_valid;
        exp_valid = m_busy && (cyc >= m_valid_cyc);
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (exp_valid) checkOutput("out_data", out_data, m_result);
        if (!reset_n) checkOutput("out_data_rst", out_data, '0);
    end

    task automatic applyStimulus(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] op,
                                 input int hold, input bit keep_valid,
                                 output logic [W-1:0] got, output int lat, output int acc);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        @(posedge clock);
        #1;
        acc      = cyc;
        in_valid = keep_valid;
        in_data  = $urandom;
        in_shamt = SW'($urandom);
        in_op    = 2'($urandom);
        lat = -1;
        got = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) begin
                lat = cyc - acc;
                break;
            end
            out_ready = 1'($urandom);
        end
        if (lat < 0) begin
            checkOutput("timeout", 32'd0, 32'd1);
            out_ready = 1'b0;
            in_valid  = 1'b0;
            return;
        end
        out_ready = 1'b0;
        got = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            checkOutput("hold_data", out_data, got);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'($urandom);
    endtask

    initial begin
        logic [W-1:0] got;
        int lat, acc, acc_prev;

        repeat (3) @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);

        applyStimulus(32'h0000_0001, 5'd1, 2'b00, 0, 1'b0, got, lat, acc);
        checkOutput("sll1", got, 32'h0000_0002);
        checkOutput("sll1_lat", 32'(lat), 32'd5);
        applyStimulus(32'h8000_0000, 5'd4, 2'b10, 0, 1'b0, got, lat, acc);
        checkOutput("sra4", got, 32'hF800_0000);
        applyStimulus(32'h8000_0000, 5'd31, 2'b01, 0, 1'b0, got, lat, acc);
        checkOutput("srl31", got, 32'h0000_0001);
        applyStimulus(32'h8000_000F, 5'd4, 2'b11, 0, 1'b0, got, lat, acc);
        checkOutput("rol4", got, 32'h0000_00F8);
        for (int op = 0; op < 4; op++) begin
            applyStimulus(32'h8000_000F, 5'd0, 2'(op), 0, 1'b0, got, lat, acc);
            checkOutput("shamt0", got, 32'h8000_000F);
            checkOutput("shamt0_lat", 32'(lat), 32'd5);
        end

        applyStimulus(32'h1234_5678, 5'd8, 2'b11, 10, 1'b0, got, lat, acc);
        checkOutput("rol8_hold", got, 32'h3456_7812);

        applyStimulus(32'hF000_0001, 5'd3, 2'b10, 0, 1'b1, got, lat, acc_prev);
        checkOutput("b2b_sra3", got, 32'hFE00_0000);
        applyStimulus(32'h0000_00FF, 5'd16, 2'b00, 0, 1'b1, got, lat, acc);
        checkOutput("b2b_sll16", got, 32'h00FF_0000);
        checkOutput("b2b_space1", 32'(acc - acc_prev), 32'(SW + 2));
        acc_prev = acc;
        applyStimulus(32'hABCD_0000, 5'd20, 2'b01, 0, 1'b0, got, lat, acc);
        checkOutput("b2b_srl20", got, 32'h0000_0ABC);
        checkOutput("b2b_space2", 32'(acc - acc_prev), 32'(SW + 2));

        // Abort an operation in SHIFT stage 2 and restart straight after release.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd31;
        in_op    = 2'b11;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
        applyStimulus(32'h0000_0F0F, 5'd2, 2'b00, 0, 1'b0, got, lat, acc);
        checkOutput("post_rst", got, 32'h0000_3C3C);
        checkOutput("post_rst_lat", 32'(lat), 32'd5);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0]  d;
            logic [SW-1:0] s;
            logic [1:0]    op;
            bit            kv;
            d  = $urandom;
            s  = SW'($urandom);
            op = 2'($urandom);
            kv = (i == 39) ? 1'b0 : 1'($urandom);
            applyStimulus(d, s, op, int'($urandom_range(3, 0)), kv, got, lat, acc);
            checkOutput("rand_result", got, ref_shift(d, int'(s), op));
            checkOutput("rand_lat", 32'(lat), 32'(SW));
        end

        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; power of two, >= 2.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width and number of shift stages.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port in_data  input  WIDTH  operand A.
REQ-008 SHALL have port in_shamt  input  SHAMT_W  shift amount.
REQ-009 SHALL have port in_op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out_data  output  WIDTH  shifted result.

Function
REQ-013 SHALL implement states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL accept a request on a rising edge with in_valid=1 while in IDLE, then capture in_data, in_shamt and in_op, clear stage counter k to 0, and go to SHIFT.
REQ-016 SHALL, at each SHIFT edge, shift the working register by 2^k positions in the captured mode if captured shamt[k]=1 (otherwise leave it unchanged), then increment k.
REQ-017 SHALL leave SHIFT for DONE on the edge that processes stage k=SHAMT_W-1, so that out_valid rises exactly SHAMT_W edges after the accepting edge (5 for WIDTH=32).
REQ-018 SHALL fill vacated bits with 0 for SLL and SRL, fill with the captured operand's MSB for SRA, and wrap MSBs into LSBs for ROL.
REQ-019 SHALL accept shamt=0 with unchanged latency and return out_data equal to the captured operand.
REQ-020 SHALL hold out_data and out_valid stable in DONE until out_ready=1; on that edge it SHALL go to IDLE and deassert out_valid.
REQ-021 SHALL NOT accept a new request on the same edge a result is consumed; the next acceptance is possible one edge later at the earliest.
REQ-022 SHALL ignore in_data, in_shamt and in_op outside the accepting edge; input changes during SHIFT or DONE SHALL NOT affect the result.
REQ-023 SHALL drive out_data as the working register, valid only while out_valid=1.
REQ-024 SHALL ignore out_ready while not in DONE.

Reset
REQ-025 SHALL, while reset_n=0, immediately (without waiting for a clock edge) force state IDLE, k=0, working register 0, out_valid=0, out_data=0, and in_ready=1.
REQ-026 SHALL, on reset asserted in SHIFT or DONE, discard the in-flight operation and produce no out_valid pulse for it after release.
REQ-027 SHALL accept a request on the first rising edge after reset_n returns to 1 if in_valid=1.

Verification
REQ-028 SHALL be verified with: WIDTH=32, in_data=0x0000_0001, shamt=1, SLL, out_ready=1 -> out_valid 5 edges after acceptance, out_data=0x0000_0002, then back to IDLE.
REQ-029 SHALL be verified with: in_data=0x8000_0000, shamt=4, SRA -> 0xF800_0000; same operand with shamt=31, SRL -> 0x0000_0001.
REQ-030 SHALL be verified with: in_data=0x8000_000F, shamt=4, ROL -> 0x0000_00F8; shamt=0, any mode -> 0x8000_000F.
REQ-031 SHALL be verified with: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data held, in_ready=0 throughout; out_ready=1 -> consumed in one cycle, and in_ready=1 on the following cycle.
REQ-032 SHALL be verified with: reset_n pulsed low during SHIFT stage 2 -> outputs immediately at reset values, no result emitted, next request processed correctly.
REQ-033 SHALL be verified with: back-to-back requests with in_valid held high -> each result correct and acceptances spaced SHAMT_W+2 edges apart.
